// File: rtl/display_buttons_pkg.sv
// Shared types and default constants for the display-board button scanner.
//   buttonsT     : named view of the 16-bit button word (MSB first).
//   scan_state_t : scan sequencer states.
//   *_DEF        : default values for the scanner parameters.
package display_buttons_pkg;

  localparam int unsigned CLK_DIV_DEF        = 25;
  localparam int unsigned N_BITS_DEF         = 16;
  localparam int unsigned DEBOUNCE_SCANS_DEF = 3;

  // Field order matches the shift-register chain, first-shifted bit at the MSB
  typedef struct packed {
    logic diall_click;
    logic dialr_click;
    logic nav_l;
    logic nav_u;
    logic nav_r;
    logic nav_d;
    logic button_x;
    logic button_y;
    logic button_b;
    logic button_a;
    logic spare0;
    logic touch_irq;
    logic spare1;
    logic spare2;
    logic nav_click;
    logic temperature_alarm;
  } buttonsT;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/display_buttons_scan_debounce.sv
// Per-bit debounce counters for the button scanner (module buttons_debounce).
// Only instantiated when BUTTONS_DEBOUNCE_EN is defined.
//   clk, reset_n  : clock, async active-low reset
//   commit        : one-clk strobe at the end of a scan
//   sample        : active-high button word from the finished scan
//   buttons_cur   : currently presented button word
//   buttons_nxt_c : button word to present after this commit (combinational)
module buttons_debounce
  import display_buttons_pkg::*;
#(
  parameter int unsigned N_BITS         = N_BITS_DEF,
  parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              commit,
  input  logic [N_BITS-1:0] sample,
  input  logic [N_BITS-1:0] buttons_cur,
  output logic [N_BITS-1:0] buttons_nxt_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt_q [N_BITS];
  logic [CW-1:0] cnt_d [N_BITS];

  // A bit flips on the DEBOUNCE_SCANS-th consecutive disagreeing scan; the
  // counter is cleared at that point so it never exceeds DEBOUNCE_SCANS-1.
  always_comb begin
    buttons_nxt_c = buttons_cur;
    cnt_d         = cnt_q;
    if (commit) begin
      for (int i = 0; i < int'(N_BITS); i++) begin
        if (sample[i] == buttons_cur[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_SCANS - 1)) begin
          buttons_nxt_c[i] = sample[i];
          cnt_d[i]         = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_BITS); i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_buttons_scan.sv
// Serial reader for the display board's PISO button shift register.
// Loads the register, clocks out N_BITS bits, synchronises them and presents
// an active-high button word once per scan.
// Optional feature macro: BUTTONS_DEBOUNCE_EN (per-bit debounce counters).
//   clk, reset_n    : system clock, async active-low reset
//   shift_in        : serial data from the register (raw bits active-low)
//   shift_loadn     : parallel load to the register, active-low
//   shift_clk       : shift clock to the register
//   buttons         : button word, 1 = pressed, first-shifted bit at MSB
//   buttons_valid   : one-clk pulse per completed scan
//   buttons_changed : one-clk pulse with buttons_valid when buttons changed
module display_buttons_scan
  import display_buttons_pkg::*;
#(
  parameter int unsigned CLK_DIV        = CLK_DIV_DEF,
  parameter int unsigned N_BITS         = N_BITS_DEF,
  parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shift_in,
  output logic              shift_loadn,
  output logic              shift_clk,
  output logic [N_BITS-1:0] buttons,
  output logic              buttons_valid,
  output logic              buttons_changed
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  // Elaboration-time parameter legality
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end

  logic [1:0]        sync_q, sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_c;
  scan_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic              commit_c;
  logic [N_BITS-1:0] sample_c;
  logic [N_BITS-1:0] buttons_nxt_c;

  logic              shift_loadn_q, shift_loadn_d;
  logic              shift_clk_q, shift_clk_d;
  logic [N_BITS-1:0] buttons_q, buttons_d;
  logic              buttons_valid_q, buttons_valid_d;
  logic              buttons_changed_q, buttons_changed_d;

  // Two-flop synchroniser on the serial input
  assign sync_d = {sync_q[0], shift_in};

  // Tick divider: one tick per shift-clock half-period
  assign tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  // FSM state register (with bit index and captured word)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      idx_q   <= IDX_W'(N_BITS - 1);
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // FSM next state; data is captured on the last clk of each LOW phase
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (tick_c) begin
      case (state_q)
        LOAD: begin
          state_d = LOW;
          idx_d   = IDX_W'(N_BITS - 1);
        end
        LOW: begin
          shift_d[idx_q] = sync_q[1];
          state_d        = (idx_q == '0) ? DONE : HIGH;
        end
        HIGH: begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = LOW;
        end
        DONE:    state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  assign commit_c = tick_c && (state_q == DONE);
  assign sample_c = ~shift_q;

`ifdef BUTTONS_DEBOUNCE_EN
  buttons_debounce #(
    .N_BITS         (N_BITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk           (clk),
    .reset_n       (reset_n),
    .commit        (commit_c),
    .sample        (sample_c),
    .buttons_cur   (buttons_q),
    .buttons_nxt_c (buttons_nxt_c)
  );
`else
  assign buttons_nxt_c = sample_c;
`endif

  // FSM outputs, decoded from the next state so the pins change with it
  always_comb begin
    shift_loadn_d     = (state_d != LOAD);
    shift_clk_d       = (state_d == HIGH);
    buttons_valid_d   = commit_c;
    buttons_d         = buttons_q;
    buttons_changed_d = 1'b0;
    if (commit_c) begin
      buttons_d         = buttons_nxt_c;
      buttons_changed_d = (buttons_nxt_c != buttons_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_loadn_q     <= 1'b1;
      shift_clk_q       <= 1'b0;
      buttons_q         <= '0;
      buttons_valid_q   <= 1'b0;
      buttons_changed_q <= 1'b0;
    end else begin
      shift_loadn_q     <= shift_loadn_d;
      shift_clk_q       <= shift_clk_d;
      buttons_q         <= buttons_d;
      buttons_valid_q   <= buttons_valid_d;
      buttons_changed_q <= buttons_changed_d;
    end
  end

  assign shift_loadn     = shift_loadn_q;
  assign shift_clk       = shift_clk_q;
  assign buttons         = buttons_q;
  assign buttons_valid   = buttons_valid_q;
  assign buttons_changed = buttons_changed_q;

endmodule

// File: tb/tb_display_buttons_scan.sv
// Bench for display_buttons_scan: 74HC165 model, scoreboard of expected
// scan results, waveform-shape checker and an asynchronous reset check.
module tb_display_buttons_scan;

  localparam int SCAN = 825;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        shift_in;
  logic        shift_loadn;
  logic        shift_clk;
  logic [15:0] buttons;
  logic        buttons_valid;
  logic        buttons_changed;

  int total = 0;
  int bad   = 0;

  display_buttons_scan dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .shift_in        (shift_in),
    .shift_loadn     (shift_loadn),
    .shift_clk       (shift_clk),
    .buttons         (buttons),
    .buttons_valid   (buttons_valid),
    .buttons_changed (buttons_changed)
  );

  always #10 clk = ~clk;

  // 74HC165 model: parallel load while loadn low, shift on shift_clk rise
  logic [15:0] raw = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;
  logic        sclk_prev = 1'b0;
  always @(posedge clk) begin
    if (!shift_loadn) sr <= raw;
    else if (shift_clk && !sclk_prev) sr <= {sr[14:0], 1'b1};
    sclk_prev <= shift_clk;
  end
  assign shift_in = sr[15];

  // Cycles since reset release
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] btn;
    logic        chg;
    int          at;
  } exp_t;
  exp_t q[$];

  // Monitor: pop and compare on each valid pulse
  always @(negedge clk) begin
    if (reset_n && buttons_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("buttons", 32'(buttons), 32'(e.btn));
        chk("changed", 32'(buttons_changed), 32'(e.chg));
        chk("valid_time", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Waveform shape: loadn/high/low phase lengths and rising edges per scan
  int  lo_run, hi_run, low_run, rises;
  bit  first_load, prev_sclk;
  always @(negedge clk) begin
    if (!reset_n) begin
      lo_run = 0; hi_run = 0; low_run = 0; rises = 0;
      first_load = 1'b1; prev_sclk = 1'b0;
    end else begin
      if (!shift_loadn) lo_run++;
      else if (lo_run != 0) begin
        if (!first_load) chk("loadn_low_len", 32'(lo_run), 32'd25);
        first_load = 1'b0;
        lo_run = 0;
      end
      if (shift_clk) hi_run++;
      else if (hi_run != 0) begin
        chk("high_len", 32'(hi_run), 32'd25);
        hi_run = 0;
      end
      if (shift_clk && !prev_sclk) begin
        rises++;
        chk("low_len", 32'(low_run), 32'd25);
      end
      if (shift_loadn && !shift_clk) low_run++;
      else low_run = 0;
      prev_sclk = shift_clk;
      if (buttons_valid) begin
        chk("rises_per_scan", 32'(rises), 32'd15);
        rises = 0;
      end
    end
  end

  task automatic wait_valid();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (buttons_valid) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic scan(input logic [15:0] r, input logic [15:0] b, input logic c, input int k);
    exp_t e;
    raw = r;
    e.btn = b; e.chg = c; e.at = k * SCAN;
    q.push_back(e);
    wait_valid();
  endtask

`ifdef BUTTONS_DEBOUNCE_EN
  localparam int NV = 10;
  logic [15:0] v_raw [NV] = '{16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFE,
                              16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [15:0] v_btn [NV] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
  logic        v_chg [NV] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
  localparam logic [15:0] POST_BTN = 16'h0000;
  localparam logic        POST_CHG = 1'b0;
`else
  localparam int NV = 8;
  logic [15:0] v_raw [NV] = '{16'hA5C3, 16'hA5C3, 16'hFFFF, 16'hFDFF,
                              16'hFFFF, 16'hFFFF, 16'h0000, 16'h7FFE};
  logic [15:0] v_btn [NV] = '{16'h5A3C, 16'h5A3C, 16'h0000, 16'h0200,
                              16'h0000, 16'h0000, 16'hFFFF, 16'h8001};
  logic        v_chg [NV] = '{1, 0, 1, 1, 1, 0, 1, 1};
  localparam logic [15:0] POST_BTN = 16'h5A3C;
  localparam logic        POST_CHG = 1'b1;
`endif

  initial begin
    raw = v_raw[0];
    repeat (3) @(negedge clk);
    chk("rst_loadn", 32'(shift_loadn), 32'd1);
    chk("rst_sclk", 32'(shift_clk), 32'd0);
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_valid", 32'(buttons_valid), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < NV; i++) scan(v_raw[i], v_btn[i], v_chg[i], i + 1);

    // Reset in the middle of a scan, during a HIGH phase (tick 10)
    repeat (250) @(negedge clk);
    chk("pre_rst_sclk", 32'(shift_clk), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_loadn", 32'(shift_loadn), 32'd1);
    chk("async_sclk", 32'(shift_clk), 32'd0);
    chk("async_buttons", 32'(buttons), 32'd0);
    repeat (3) @(negedge clk);
    raw = 16'hA5C3;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_load", 32'(shift_loadn), 32'd0);
    scan(16'hA5C3, POST_BTN, POST_CHG, 1);
    scan(16'hA5C3, POST_BTN, 1'b0, 2);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
